bus_target_mem: RTL



---
 rtl/bus_target_mem_pkg.sv | 26 ++
 rtl/bus_target_mem_if.sv | 42 ++++
 rtl/bus_target_mem_sync.sv | 30 +++
 rtl/bus_target_mem.sv | 123 ++++++++++++
 4 files changed

// File: rtl/bus_target_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_mem_pkg
// Description : Phase codes and FSM state encodings shared by the 8080 bus
//               target, its bus interface and the benches that drive it.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_target_mem_pkg;

    localparam logic [1:0] PH_ADDR_LO = 2'd0;
    localparam logic [1:0] PH_ADDR_HI = 2'd1;
    localparam logic [1:0] PH_READ    = 2'd2;
    localparam logic [1:0] PH_WRITE   = 2'd3;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_MEM     = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bus_target_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_mem_if
// Description : Chip-side request/handshake bus plus the local backing-store
//               port; slave = the target, master = chip and memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_target_mem_if;
    import bus_target_mem_pkg::*;

    logic        bus_handshake_req;
    logic [1:0]  bus_state;          // one of the PH_* codes
    logic        bus_io;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        bus_handshake_ack;

    logic [15:0] mem_addr;
    logic        mem_io;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport slave (
        input  bus_handshake_req, bus_state, bus_io, bus_data_in,
        input  mem_rdata, mem_ready,
        output bus_data_out, bus_data_oe, bus_handshake_ack,
        output mem_addr, mem_io, mem_read, mem_write, mem_wdata
    );

    modport master (
        output bus_handshake_req, bus_state, bus_io, bus_data_in,
        output mem_rdata, mem_ready,
        input  bus_data_out, bus_data_oe, bus_handshake_ack,
        input  mem_addr, mem_io, mem_read, mem_write, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/bus_target_mem_sync.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_mem_sync
// Description : Flop-chain synchroniser for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_target_mem_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d_i,
    output logic      q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bus_target_mem.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_mem
// Description : 8080 chip-bus target: decodes address/data phases under the
//               four-phase handshake and services them on a backing store.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_target_mem
    import bus_target_mem_pkg::*;
#(
    parameter bit AUTO_INC = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bus_target_mem_if.slave  bus
);

    state_e      state_q, state_d;
    logic        req_s;
    logic        req_prev_q;
    logic        req_rise;
    logic [1:0]  phase_q;
    logic [7:0]  data_q;
    logic [15:0] addr_q;
    logic        mem_io_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [7:0]  rdata_q;
    logic        oe_q;
    logic        mem_busy;
    logic        ack;

    // Syncing flops reset high so a request already asserted at reset release
    // cannot look like a fresh rising edge.
    bus_target_mem_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.bus_handshake_req),
        .q_o   (req_s)
    );

    assign req_rise = req_s & ~req_prev_q;
    assign mem_busy = mem_read_q | mem_write_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_rise) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = phase_q[1] ? ST_MEM : ST_ACK;
            ST_MEM:     if (!mem_busy) state_d = ST_ACK;
            ST_ACK:     if (!req_s) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack = 1'b0;
        if (state_q == ST_ACK) ack = 1'b1;
    end

    // The bus fields are captured on the edge that enters CAPTURE, so the
    // memory request is already presented during CAPTURE. MEM then waits for
    // the request to retire, which leaves read data one cycle ahead of ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q  <= 1'b1;
            phase_q     <= PH_ADDR_LO;
            data_q      <= 8'h00;
            addr_q      <= 16'h0000;
            mem_io_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rdata_q     <= 8'h00;
            oe_q        <= 1'b0;
        end else begin
            req_prev_q <= req_s;
            if (state_q == ST_IDLE && req_rise) begin
                phase_q     <= bus.bus_state;
                data_q      <= bus.bus_data_in;
                mem_read_q  <= (bus.bus_state == PH_READ);
                mem_write_q <= (bus.bus_state == PH_WRITE);
                if (bus.bus_state[1]) mem_io_q <= bus.bus_io;
            end
            if (state_q == ST_CAPTURE) begin
                if (phase_q == PH_ADDR_LO) addr_q[7:0]  <= data_q;
                if (phase_q == PH_ADDR_HI) addr_q[15:8] <= data_q;
            end
            if (mem_busy && bus.mem_ready) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (mem_read_q) begin
                    rdata_q <= bus.mem_rdata;
                    oe_q    <= 1'b1;
                end
                if (AUTO_INC) addr_q <= addr_q + 16'd1;
            end
            if (state_q == ST_ACK && !req_s) oe_q <= 1'b0;
        end
    end

    assign bus.bus_handshake_ack = ack;
    assign bus.bus_data_out      = rdata_q;
    assign bus.bus_data_oe       = oe_q;
    assign bus.mem_addr          = addr_q;
    assign bus.mem_io            = mem_io_q;
    assign bus.mem_read          = mem_read_q;
    assign bus.mem_write         = mem_write_q;
    assign bus.mem_wdata         = data_q;

endmodule
`default_nettype wire
